// File: rtl/synth_pkg.sv
// Shared synth definitions: Q12.20 constants, voice / control state encodings
// and the PS/2 set-2 key-code to frequency table (just intonation from A2=110 Hz).
package synth_pkg;

    localparam logic [31:0] ONE    = 32'h0010_0000;   // 1.0 in Q12.20
    localparam int          FRAC_W = 20;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        HELD    = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] freq;
    } rom_entry_t;

    // Frequencies are f_hz * 2^20, truncated.
    function automatic rom_entry_t key_freq(input logic [7:0] code);
        rom_entry_t r;
        r = '{hit: 1'b0, freq: 32'd0};
        case (code)
            8'h15: r = '{hit: 1'b1, freq: 32'd115343360};  // 110.000
            8'h16: r = '{hit: 1'b1, freq: 32'd123032917};  // 117.333
            8'h1D: r = '{hit: 1'b1, freq: 32'd129761280};  // 123.750
            8'h1E: r = '{hit: 1'b1, freq: 32'd138412032};  // 132.000
            8'h24: r = '{hit: 1'b1, freq: 32'd144179200};  // 137.500
            8'h26: r = '{hit: 1'b1, freq: 32'd153791146};  // 146.667
            8'h2D: r = '{hit: 1'b1, freq: 32'd162201600};  // 154.688
            8'h2C: r = '{hit: 1'b1, freq: 32'd173015040};  // 165.000
            8'h2E: r = '{hit: 1'b1, freq: 32'd184549376};  // 176.000
            8'h35: r = '{hit: 1'b1, freq: 32'd192238933};  // 183.333
            8'h36: r = '{hit: 1'b1, freq: 32'd207618048};  // 198.000
            8'h3C: r = '{hit: 1'b1, freq: 32'd216268800};  // 206.250
            8'h3D: r = '{hit: 1'b1, freq: 32'd230686720};  // 220.000
            default: r = '{hit: 1'b0, freq: 32'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_freq_rom.sv
// Registered 1-clk key-code lookup.
//   clk, reset : clock, synchronous active-high reset
//   lookup     : capture a new lookup this cycle
//   code       : PS/2 make code
//   hit, freq  : table hit flag and Q12.20 frequency, valid the cycle after lookup
module key_freq_rom
    import synth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup,
    input  logic [7:0]  code,
    output logic        hit,
    output logic [31:0] freq
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit  <= 1'b0;
            freq <= 32'd0;
        end else if (lookup) begin
            {hit, freq} <= key_freq(code);
        end
    end

endmodule

// File: rtl/voice_slot.sv
// One voice: state, stored code, age, frequency, volume and gate registers,
// plus the linear release ramp.
//   alloc       : take a new key this cycle (wins over everything else)
//   release_req : key-up for this HELD voice
//   age_inc     : another voice was allocated; grow older (saturating)
//   new_code, new_freq : key being allocated
//   state, code, age, freq, volume, gate : registered voice state
module voice_slot
    import synth_pkg::*;
#(
    parameter logic [31:0] RELEASE_STEP = 32'h0010_0000,
    parameter int          AGE_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc,
    input  logic             release_req,
    input  logic             age_inc,
    input  logic [7:0]       new_code,
    input  logic [31:0]      new_freq,
    output voice_state_t     state,
    output logic [7:0]       code,
    output logic [AGE_W-1:0] age,
    output logic [31:0]      freq,
    output logic [31:0]      volume,
    output logic             gate
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FREE;
            code   <= 8'd0;
            age    <= '0;
            freq   <= 32'd0;
            volume <= 32'd0;
            gate   <= 1'b0;
        end else if (alloc) begin
            // Allocation overrides any ramp step happening this clk.
            state  <= HELD;
            code   <= new_code;
            age    <= '0;
            freq   <= new_freq;
            volume <= ONE;
            gate   <= 1'b1;
        end else begin
            if (age_inc && (age != '1))
                age <= age + 1'b1;
            case (state)
                HELD: begin
                    if (release_req) begin
                        gate  <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // volume > step keeps the result nonzero, so 0 only
                    // ever comes from the clamp branch, which also frees.
                    if (volume > RELEASE_STEP) begin
                        volume <= volume - RELEASE_STEP;
                    end else begin
                        volume <= 32'd0;
                        state  <= FREE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler. Key press/release events are accepted one per
// two clocks (IDLE -> APPLY); a press retriggers the voice already holding the
// key, else takes the lowest free voice, else steals the oldest voice.
//   clk, reset          : clock, synchronous active-high reset
//   ev_valid/ev_ready   : event handshake
//   ev_pressed, ev_code : key down/up and PS/2 make code
//   frequencies         : per-voice Q12.20 frequency
//   voice_volumes       : per-voice Q12.20 volume
//   voice_gate          : per-voice key-held flag
//   busy                : any voice not FREE
module voice_allocator
    import synth_pkg::*;
#(
    parameter int          NUM_VOICES   = 8,
    parameter logic [31:0] RELEASE_STEP = 32'h0010_0000,
    parameter int          AGE_W        = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_pressed,
    input  logic [7:0]                   ev_code,
    output logic [NUM_VOICES-1:0][31:0]  frequencies,
    output logic [NUM_VOICES-1:0][31:0]  voice_volumes,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic                         busy
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    ctrl_state_t fsm;
    logic        pressed_q;
    logic [7:0]  code_q;
    logic        rom_hit;
    logic [31:0] rom_freq;

    voice_state_t                     vstate [NUM_VOICES];
    logic [NUM_VOICES-1:0][7:0]       vcode;
    logic [NUM_VOICES-1:0][AGE_W-1:0] vage;

    logic [NUM_VOICES-1:0] active, match, held_match;
    logic [NUM_VOICES-1:0] alloc, age_inc, rel;
    logic                  any_match, any_free;
    logic [IDX_W-1:0]      match_idx, free_idx, old_idx, pick_idx;
    logic [AGE_W-1:0]      old_age;
    logic                  do_press, do_rel;

    // ---- control FSM ------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            ev_ready  <= 1'b0;
            pressed_q <= 1'b0;
            code_q    <= 8'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        pressed_q <= ev_pressed;
                        code_q    <= ev_code;
                        ev_ready  <= 1'b0;
                        fsm       <= APPLY;
                    end else begin
                        ev_ready  <= 1'b1;
                    end
                end
                APPLY: begin
                    ev_ready <= 1'b1;
                    fsm      <= IDLE;
                end
                default: begin
                    ev_ready <= 1'b0;
                    fsm      <= IDLE;
                end
            endcase
        end
    end

    // Lookup launches on the handshake; result is ready during APPLY.
    key_freq_rom u_rom (
        .clk    (clk),
        .reset  (reset),
        .lookup (ev_valid && ev_ready),
        .code   (ev_code),
        .hit    (rom_hit),
        .freq   (rom_freq)
    );

    // ---- voice selection --------------------------------------------------
    assign do_press = (fsm == APPLY) && pressed_q && rom_hit;
    assign do_rel   = (fsm == APPLY) && !pressed_q;

    always_comb begin
        any_match = 1'b0;
        any_free  = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active[i]     = (vstate[i] != FREE);
            match[i]      = active[i] && (vcode[i] == code_q);
            held_match[i] = (vstate[i] == HELD) && (vcode[i] == code_q);
        end
        // Descending scan so the lowest index is the one left standing.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!active[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        // Strict '>' keeps ties on the lower index.
        old_idx = '0;
        old_age = vage[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (vage[i] > old_age) begin
                old_age = vage[i];
                old_idx = IDX_W'(i);
            end
        end
        pick_idx = any_match ? match_idx : (any_free ? free_idx : old_idx);
        for (int i = 0; i < NUM_VOICES; i++) begin
            alloc[i]   = do_press && (pick_idx == IDX_W'(i));
            age_inc[i] = do_press && active[i];
            rel[i]     = do_rel && held_match[i];
        end
    end

    assign busy = |active;

    // ---- per-voice state --------------------------------------------------
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        voice_slot #(
            .RELEASE_STEP (RELEASE_STEP),
            .AGE_W        (AGE_W)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .alloc       (alloc[g]),
            .release_req (rel[g]),
            .age_inc     (age_inc[g]),
            .new_code    (code_q),
            .new_freq    (rom_freq),
            .state       (vstate[g]),
            .code        (vcode[g]),
            .age         (vage[g]),
            .freq        (frequencies[g]),
            .volume      (voice_volumes[g]),
            .gate        (voice_gate[g])
        );
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: expectations are queued as events are
// driven and compared once the allocator has had time to commit them.
module tb_voice_allocator;

    localparam int          NV  = 8;
    localparam logic [31:0] ONE = 32'h0010_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_pressed = 1'b0;
    logic [7:0] ev_code = 8'd0;
    logic       sel = 1'b0;   // 0: default-step DUT, 1: slow-ramp DUT

    always #5 clk = ~clk;

    logic                 rdy_a, rdy_b, busy_a, busy_b;
    logic [NV-1:0][31:0]  fa, fb, va, vb;
    logic [NV-1:0]        ga, gb;
    wire                  ev_ready = sel ? rdy_b : rdy_a;

    voice_allocator #(.NUM_VOICES(NV)) dut_a (
        .clk(clk), .reset(reset), .ev_valid(ev_valid && !sel), .ev_ready(rdy_a),
        .ev_pressed(ev_pressed), .ev_code(ev_code), .frequencies(fa),
        .voice_volumes(va), .voice_gate(ga), .busy(busy_a)
    );

    voice_allocator #(.NUM_VOICES(NV), .RELEASE_STEP(32'h0004_0000)) dut_b (
        .clk(clk), .reset(reset), .ev_valid(ev_valid && sel), .ev_ready(rdy_b),
        .ev_pressed(ev_pressed), .ev_code(ev_code), .frequencies(fb),
        .voice_volumes(vb), .voice_gate(gb), .busy(busy_b)
    );

    int hs_cnt = 0;
    always @(posedge clk) if (ev_valid && ev_ready) hs_cnt <= hs_cnt + 1;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        string       tag;
        int          kind;   // 0 freq, 1 vol, 2 gate, 3 busy, 4 ready
        int          voice;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int kind, input int v);
        case (kind)
            0: return sel ? fb[v] : fa[v];
            1: return sel ? vb[v] : va[v];
            2: return {31'd0, sel ? gb[v] : ga[v]};
            3: return {31'd0, sel ? busy_b : busy_a};
            default: return {31'd0, ev_ready};
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input int v, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.voice = v; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.kind, e.voice), e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at handshake edge + 1.
    task automatic send(input logic p, input logic [7:0] c);
        int n;
        @(negedge clk);
        ev_valid = 1'b1; ev_pressed = p; ev_code = c;
        n = 0;
        while (!ev_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ev_ready) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    function automatic logic [31:0] hz(input logic [7:0] c);
        case (c)
            8'h15: return 32'd115343360;
            8'h16: return 32'd123032917;
            8'h1D: return 32'd129761280;
            8'h2C: return 32'd173015040;
            8'h2E: return 32'd184549376;
            8'h35: return 32'd192238933;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_all_zero(input string tag);
        for (int v = 0; v < NV; v++) begin
            push({tag, "_freq"}, 0, v, 32'd0);
            push({tag, "_vol"},  1, v, 32'd0);
            push({tag, "_gate"}, 2, v, 32'd0);
        end
        push({tag, "_busy"}, 3, 0, 32'd0);
    endtask

    initial begin
        logic [7:0] nine [9];
        int         hs0;
        nine = '{8'h15, 8'h16, 8'h1D, 8'h1E, 8'h24, 8'h26, 8'h2D, 8'h2C, 8'h2E};

        // 1: reset and idle
        tick(3);
        push("rst_ready_low", 4, 0, 32'd0);
        drain();
        @(negedge clk) reset = 1'b0;
        tick(4);
        push_all_zero("idle");
        push("idle_ready", 4, 0, 32'd1);
        drain();

        // 2: single press / default-step release
        push("p15_freq", 0, 0, hz(8'h15));
        push("p15_vol",  1, 0, ONE);
        push("p15_gate", 2, 0, 32'd1);
        push("p15_busy", 3, 0, 32'd1);
        send(1'b1, 8'h15); tick(2); drain();
        send(1'b0, 8'h15);
        push("r15_gate", 2, 0, 32'd0);
        push("r15_vol_e1", 1, 0, ONE);
        tick(1); drain();
        push("r15_vol_e2", 1, 0, 32'd0);
        push("r15_busy", 3, 0, 32'd0);
        tick(1); drain();
        push("r15_freq_kept", 0, 0, hz(8'h15));
        tick(1); drain();

        // 3: two voices, independent release
        send(1'b1, 8'h2C);
        send(1'b1, 8'h16);
        push("two_v0_freq", 0, 0, hz(8'h2C));
        push("two_v1_freq", 0, 1, hz(8'h16));
        push("two_v0_vol",  1, 0, ONE);
        push("two_v1_vol",  1, 1, ONE);
        tick(2); drain();
        send(1'b0, 8'h2C);
        push("r2c_v0_vol",  1, 0, 32'd0);
        push("r2c_v0_gate", 2, 0, 32'd0);
        push("r2c_v1_vol",  1, 1, ONE);
        push("r2c_v1_gate", 2, 1, 32'd1);
        push("r2c_busy",    3, 0, 32'd1);
        tick(2); drain();
        send(1'b0, 8'h16);
        push("r16_v1_vol", 1, 1, 32'd0);
        push("r16_busy",   3, 0, 32'd0);
        tick(2); drain();

        // 4: slow ramp on the 1<<18 instance
        sel = 1'b1;
        send(1'b1, 8'h15);
        push("slow_press_vol", 1, 0, ONE);
        tick(2); drain();
        send(1'b0, 8'h15);
        push("slow_e1", 1, 0, ONE);     tick(1); drain();
        push("slow_e2", 1, 0, 32'd786432); tick(1); drain();
        push("slow_e3", 1, 0, 32'd524288); tick(1); drain();
        push("slow_e4", 1, 0, 32'd262144); tick(1); drain();
        push("slow_e5", 1, 0, 32'd0);
        push("slow_free", 3, 0, 32'd0);
        tick(1); drain();
        sel = 1'b0;

        // 5: steal oldest, then retrigger
        for (int k = 0; k < 9; k++) send(1'b1, nine[k]);
        push("steal_v0", 0, 0, hz(8'h2E));
        push("steal_v1_kept", 0, 1, hz(8'h16));
        push("steal_v7_kept", 0, 7, hz(8'h2C));
        push("steal_v0_gate", 2, 0, 32'd1);
        tick(2); drain();
        // voice0 age was reset by the steal, so voice1 is now the oldest
        send(1'b1, 8'h35);
        push("steal2_v1", 0, 1, hz(8'h35));
        push("steal2_v0_kept", 0, 0, hz(8'h2E));
        tick(2); drain();
        send(1'b1, 8'h2C);
        push("retrig_v7_freq", 0, 7, hz(8'h2C));
        push("retrig_v7_vol",  1, 7, ONE);
        push("retrig_v2_kept", 0, 2, hz(8'h1D));
        push("retrig_v1_kept", 0, 1, hz(8'h35));
        tick(2); drain();

        // 6a: reset during APPLY
        send(1'b1, 8'h3C);
        reset = 1'b1;
        push_all_zero("rst_apply");
        push("rst_apply_ready", 4, 0, 32'd0);
        tick(1); drain();
        @(negedge clk) reset = 1'b0;
        tick(1);

        // 6b: ev_valid held through APPLY
        hs0 = hs_cnt;
        @(negedge clk);
        ev_valid = 1'b1; ev_pressed = 1'b1; ev_code = 8'h15;
        push("hold_apply_ready", 4, 0, 32'd0);
        tick(1); drain();
        push("hold_idle_ready", 4, 0, 32'd1);
        tick(1); drain();
        tick(1);
        @(negedge clk) ev_valid = 1'b0;
        chk("hold_handshakes", 32'(hs_cnt - hs0), 32'd2);
        tick(2);

        // 6c: unknown code, 6d: release of an unheld code
        send(1'b1, 8'hFF);
        push("unk_v1_freq", 0, 1, 32'd0);
        push("unk_v1_vol",  1, 1, 32'd0);
        push("unk_v1_gate", 2, 1, 32'd0);
        push("unk_v0_freq", 0, 0, hz(8'h15));
        tick(2); drain();
        send(1'b0, 8'h16);
        push("unheld_v0_gate", 2, 0, 32'd1);
        push("unheld_v0_vol",  1, 0, ONE);
        push("unheld_busy",    3, 0, 32'd1);
        tick(2); drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

endmodule
